// File: rtl/pkt_pkg.sv
// ============================================================================
//  pkt_pkg : shared types and defaults for the metadata depacketizer
//  Rev 1.0
// ============================================================================
`default_nettype none

package pkt_pkg;

    localparam int DATA_WIDTH_DEF = 512;
    localparam int META_WIDTH_DEF = 356;
    localparam int MAX_BEATS_DEF  = 3;

    localparam int BEAT_CNT_W = 8;
    localparam int ERR_W      = 3;

    localparam int ERR_MISSING_META    = 0;
    localparam int ERR_UNEXPECTED_META = 1;
    localparam int ERR_LONG            = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
//  axis_skid_buffer : 2-entry valid/ready buffer with registered in_ready
//  Rev 1.0
// ============================================================================
`default_nettype none

module axis_skid_buffer #(
    parameter int W = 513
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    // Ready depends only on the skid register, so no combinational path from out_ready.
    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_skid_valid) begin
            if (!out_valid || out_ready) begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end else if (in_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
            end
        end else if (out_ready) begin
            out_valid    <= 1'b1;
            out_data     <= r_skid_data;
            r_skid_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_meta_depacketizer.sv
// ============================================================================
//  axi_meta_depacketizer : strips the meta beat of each packet onto a sideband
//  port, forwards payload beats and flags framing violations.
//  Rev 1.0
// ============================================================================
`default_nettype none

module axi_meta_depacketizer
    import pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int META_WIDTH = META_WIDTH_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tlast,
    input  logic                  in_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic [META_WIDTH-1:0] meta_data,
    output logic [ERR_W-1:0]      err_pulse,
    output logic [31:0]           pkt_count,
    output logic [15:0]           err_count
);

    localparam logic [BEAT_CNT_W-1:0] c_last_beat_idx = BEAT_CNT_W'(MAX_BEATS - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_next;
    logic                  r_pkt_err;
    logic                  w_pkt_err_next;
    logic [ERR_W-1:0]      w_err;
    logic                  w_meta_load;
    logic                  w_pkt_inc;
    logic                  w_in_tready;
    logic                  w_skid_valid;
    logic                  w_skid_last;
    logic                  w_skid_ready;
    logic [DATA_WIDTH:0]   w_skid_out;

    assign in_tready = w_in_tready;

    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        w_pkt_err_next  = r_pkt_err;
        w_err           = '0;
        w_meta_load     = 1'b0;
        w_pkt_inc       = 1'b0;
        w_in_tready     = 1'b0;
        w_skid_valid    = 1'b0;
        w_skid_last     = in_tlast;
        case (r_state)
            ST_IDLE: begin
                // Holding off while meta is pending pairs each meta with exactly one payload.
                w_in_tready = !meta_valid;
                if (in_tvalid && !meta_valid) begin
                    if (in_tuser && !in_tlast) begin
                        w_meta_load     = 1'b1;
                        w_beat_cnt_next = '0;
                        w_pkt_err_next  = 1'b0;
                        w_state_next    = ST_PAYLOAD;
                    end else if (in_tuser) begin
                        // Meta-only packet: discarded and reported on the low error bit.
                        w_err[ERR_MISSING_META] = 1'b1;
                    end else begin
                        w_err[ERR_MISSING_META] = 1'b1;
                        if (!in_tlast) begin
                            w_state_next = ST_DROP;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                w_in_tready = w_skid_ready;
                if (in_tvalid && w_skid_ready) begin
                    w_skid_valid   = 1'b1;
                    w_pkt_err_next = r_pkt_err | in_tuser;
                    if (in_tuser) begin
                        w_err[ERR_UNEXPECTED_META] = 1'b1;
                    end
                    if (in_tlast) begin
                        w_pkt_inc    = !(r_pkt_err || in_tuser);
                        w_state_next = ST_IDLE;
                    end else if (r_beat_cnt == c_last_beat_idx) begin
                        w_skid_last     = 1'b1;
                        w_err[ERR_LONG] = 1'b1;
                        w_state_next    = ST_DROP;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + BEAT_CNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                w_in_tready = 1'b1;
                if (in_tvalid && in_tlast) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_pkt_err  <= 1'b0;
            meta_valid <= 1'b0;
            meta_data  <= '0;
            err_pulse  <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_pkt_err  <= w_pkt_err_next;
            err_pulse  <= w_err;
            if (w_meta_load) begin
                meta_valid <= 1'b1;
                meta_data  <= in_tdata[META_WIDTH-1:0];
            end else if (meta_valid && meta_ready) begin
                meta_valid <= 1'b0;
            end
            if (w_pkt_inc) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if ((|w_err) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    axis_skid_buffer #(
        .W (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_skid_valid),
        .in_ready  (w_skid_ready),
        .in_data   ({w_skid_last, in_tdata}),
        .out_valid (out_tvalid),
        .out_ready (out_tready),
        .out_data  (w_skid_out)
    );

    assign out_tlast = w_skid_out[DATA_WIDTH];
    assign out_tdata = w_skid_out[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_axi_meta_depacketizer.sv
// ============================================================================
//  tb_axi_meta_depacketizer : packet-vector table plus stall and reset sequences
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_meta_depacketizer;

    localparam int DW = 512;
    localparam int MW = 356;
    localparam int MB = 3;
    localparam int CW = DW + 1;
    localparam int NV = 10;

    typedef logic [CW-1:0] cw_t;

    typedef struct {
        int         n_beats;
        logic [7:0] user_mask;
        int         exp_out;
        int         exp_meta;
        logic [2:0] exp_err;
        int         exp_errs;
        int         exp_pkts;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_tvalid;
    logic          in_tready;
    logic [DW-1:0] in_tdata;
    logic          in_tlast;
    logic          in_tuser;
    logic          out_tvalid;
    logic          out_tready;
    logic [DW-1:0] out_tdata;
    logic          out_tlast;
    logic          meta_valid;
    logic          meta_ready;
    logic [MW-1:0] meta_data;
    logic [2:0]    err_pulse;
    logic [31:0]   pkt_count;
    logic [15:0]   err_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_pkt = 0;
    int            exp_errcnt = 0;
    logic          tog_en = 1'b0;
    logic          r_prev_stall;
    logic [DW:0]   r_prev_beat;
    logic [DW:0]   out_q[$];
    logic [MW-1:0] meta_q[$];
    logic [2:0]    err_q[$];
    vec_t          vecs[NV];

    axi_meta_depacketizer #(
        .DATA_WIDTH (DW),
        .META_WIDTH (MW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .in_tuser   (in_tuser),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .meta_valid (meta_valid),
        .meta_ready (meta_ready),
        .meta_data  (meta_data),
        .err_pulse  (err_pulse),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input cw_t act, input cw_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int tag, input int idx, input logic is_meta);
        logic [DW-1:0] d;
        logic [31:0]   w;
        d = '0;
        if (is_meta) begin
            d[11:0]  = 12'hABC;
            d[23:16] = 8'(tag);
            if (tag[0]) d[MW-1] = 1'b1;
        end else begin
            w = 32'hD000_0000 | (32'(tag) << 8) | 32'(idx);
            d = {16{w}};
        end
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
        int t;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tuser  = u;
        in_tlast  = l;
        t = 0;
        @(negedge clk);
        while (!in_tready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("in_handshake", cw_t'(in_tready), cw_t'(1));
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_tvalid"}, cw_t'(out_tvalid), '0);
        chk({tag, "_out_tdata"},  cw_t'(out_tdata),  '0);
        chk({tag, "_out_tlast"},  cw_t'(out_tlast),  '0);
        chk({tag, "_meta_valid"}, cw_t'(meta_valid), '0);
        chk({tag, "_meta_data"},  cw_t'(meta_data),  '0);
        chk({tag, "_err_pulse"},  cw_t'(err_pulse),  '0);
        chk({tag, "_pkt_count"},  cw_t'(pkt_count),  '0);
        chk({tag, "_err_count"},  cw_t'(err_count),  '0);
    endtask

    task automatic clear_queues();
        out_q.delete();
        meta_q.delete();
        err_q.delete();
    endtask

    task automatic run_vec(input int v, input int tag);
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        logic [MW-1:0] m_exp;
        logic [2:0]    err_or;
        clear_queues();
        for (int i = 0; i < vecs[v].n_beats; i++) begin
            d = beat_data(tag, i, vecs[v].user_mask[i]);
            send_beat(d, vecs[v].user_mask[i], i == vecs[v].n_beats - 1);
        end
        tick(8);
        exp_pkt    += vecs[v].exp_pkts;
        exp_errcnt += vecs[v].exp_errs;
        chk("out_beats", cw_t'(out_q.size()), cw_t'(vecs[v].exp_out));
        for (int j = 0; j < vecs[v].exp_out && j < out_q.size(); j++) begin
            d = beat_data(tag, j + 1, vecs[v].user_mask[j + 1]);
            chk("out_beat", cw_t'(out_q[j]), cw_t'({j == vecs[v].exp_out - 1, d}));
        end
        chk("meta_count", cw_t'(meta_q.size()), cw_t'(vecs[v].exp_meta));
        if (meta_q.size() > 0) begin
            m     = beat_data(tag, 0, 1'b1);
            m_exp = m[MW-1:0];
            chk("meta_data", cw_t'(meta_q[0]), cw_t'(m_exp));
        end
        err_or = '0;
        foreach (err_q[k]) err_or |= err_q[k];
        chk("err_flags", cw_t'(err_or), cw_t'(vecs[v].exp_err));
        chk("pkt_count", cw_t'(pkt_count), cw_t'(exp_pkt));
        chk("err_count", cw_t'(err_count), cw_t'(exp_errcnt));
    endtask

    // Output-side observer: collects transfers and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            r_prev_stall <= 1'b0;
            r_prev_beat  <= '0;
        end else begin
            if (r_prev_stall) begin
                chk("hold_valid", cw_t'(out_tvalid), cw_t'(1));
                chk("hold_beat", cw_t'({out_tlast, out_tdata}), cw_t'(r_prev_beat));
            end
            r_prev_stall <= out_tvalid && !out_tready;
            r_prev_beat  <= {out_tlast, out_tdata};
            if (out_tvalid && out_tready) out_q.push_back({out_tlast, out_tdata});
            if (meta_valid && meta_ready) meta_q.push_back(meta_data);
            if (err_pulse != 3'b000) err_q.push_back(err_pulse);
        end
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            out_tready = ~out_tready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] m1;
        logic [DW-1:0] m2;
        logic [MW-1:0] m1_exp;
        logic [MW-1:0] m2_exp;
        logic          blocked;

        //            beats  tuser mask  out meta err     errs pkts
        vecs[0] = '{4, 8'b0000_0001, 3, 1, 3'b000, 0, 1};  // nominal 3-beat payload
        vecs[1] = '{2, 8'b0000_0001, 1, 1, 3'b000, 0, 1};  // single payload beat
        vecs[2] = '{3, 8'b0000_0000, 0, 0, 3'b001, 1, 0};  // missing meta, dropped
        vecs[3] = '{6, 8'b0000_0001, 3, 1, 3'b100, 1, 0};  // 5 payload beats, too long
        vecs[4] = '{3, 8'b0000_0011, 2, 1, 3'b010, 1, 0};  // meta inside payload
        vecs[5] = '{3, 8'b0000_0001, 2, 1, 3'b000, 0, 1};  // 2 payload beats
        vecs[6] = '{1, 8'b0000_0000, 0, 0, 3'b001, 1, 0};  // lone tuser=0 tlast beat
        vecs[7] = '{4, 8'b0000_1001, 3, 1, 3'b010, 1, 0};  // tuser on the last beat
        vecs[8] = '{5, 8'b0000_0001, 3, 1, 3'b100, 1, 0};  // one beat over the limit
        vecs[9] = '{1, 8'b0000_0001, 0, 0, 3'b001, 1, 0};  // meta-only packet

        rst        = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        in_tuser   = 1'b0;
        out_tready = 1'b1;
        meta_ready = 1'b1;
        tick(3);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < NV; v++) begin
            run_vec(v, v);
        end

        // Stalled output and held-off meta consumer.
        clear_queues();
        m1         = beat_data(20, 0, 1'b1);
        m2         = beat_data(21, 0, 1'b1);
        m1_exp     = m1[MW-1:0];
        m2_exp     = m2[MW-1:0];
        meta_ready = 1'b0;
        tog_en     = 1'b1;
        send_beat(m1, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) send_beat(beat_data(20, i, 1'b0), 1'b0, i == 3);
        in_tvalid = 1'b1;
        in_tdata  = m2;
        in_tuser  = 1'b1;
        in_tlast  = 1'b0;
        blocked   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_tready || !meta_valid) blocked = 1'b0;
        end
        chk("meta2_blocked", cw_t'(blocked), cw_t'(1));
        chk("meta1_held", cw_t'(meta_data), cw_t'(m1_exp));
        @(posedge clk);
        #1;
        meta_ready = 1'b1;
        send_beat(m2, 1'b1, 1'b0);
        for (int i = 1; i <= 2; i++) send_beat(beat_data(21, i, 1'b0), 1'b0, i == 2);
        tick(12);
        tog_en = 1'b0;
        tick(1);
        out_tready = 1'b1;
        tick(10);
        exp_pkt += 2;
        chk("stall_out_beats", cw_t'(out_q.size()), cw_t'(5));
        for (int j = 0; j < 5 && j < out_q.size(); j++) begin
            if (j < 3) chk("stall_beat", cw_t'(out_q[j]), cw_t'({j == 2, beat_data(20, j + 1, 1'b0)}));
            else       chk("stall_beat", cw_t'(out_q[j]), cw_t'({j == 4, beat_data(21, j - 2, 1'b0)}));
        end
        chk("stall_meta_count", cw_t'(meta_q.size()), cw_t'(2));
        if (meta_q.size() == 2) begin
            chk("stall_meta0", cw_t'(meta_q[0]), cw_t'(m1_exp));
            chk("stall_meta1", cw_t'(meta_q[1]), cw_t'(m2_exp));
        end
        chk("stall_pkt_count", cw_t'(pkt_count), cw_t'(exp_pkt));
        chk("stall_err_count", cw_t'(err_count), cw_t'(exp_errcnt));

        // Reset in the middle of a packet, then a fresh nominal packet.
        send_beat(beat_data(30, 0, 1'b1), 1'b1, 1'b0);
        send_beat(beat_data(30, 1, 1'b0), 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("midpkt_reset");
        tick(2);
        rst        = 1'b0;
        exp_pkt    = 0;
        exp_errcnt = 0;
        tick(2);
        run_vec(0, 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
